// File: rtl/hdec_pkg.sv
// Shared constants and FSM state type for the decimating-FIR stream controller.
package hdec_pkg;

    localparam int NTAPS    = 21;
    localparam int DEC      = 5;
    localparam int FIR_LAT  = 2;
    localparam int COEF_SUM = 796;

    localparam int N_W  = $clog2(NTAPS);
    localparam int PH_W = $clog2(DEC);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FILL,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

endpackage

// File: rtl/hdec_out_fifo.sv
// Small synchronous FIFO for decimated FIR outputs; head entry is read from registered storage.
module hdec_out_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign cnt   = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A push into a full FIFO is only legal when the head leaves the same cycle.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/hdec_5_stream_ctrl.sv
// Stream controller for a 21-tap enable-gated decimating FIR: input handshake,
// warm-up suppression, 1-in-DEC output tagging, credit-based FIFO and zero-stuff flush.
module hdec_5_stream_ctrl
    import hdec_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush_req,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             fir_clr_n,
    output logic             fir_ce,
    output logic [IN_W-1:0]  fir_x,
    input  logic [OUT_W-1:0] fir_y
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int LOAD_W = CNT_W + 1;
    localparam logic [N_W-1:0]    N_LAST    = N_W'(NTAPS - 1);
    localparam logic [N_W-1:0]    FLUSH_END = N_W'(NTAPS - 2);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DEC - 1);
    localparam logic [LOAD_W-1:0] LOAD_MAX  = LOAD_W'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [N_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [FIR_LAT-1:0] tag_q, tag_d;

    logic               next_tag;
    logic               credit_ok;
    logic [CNT_W-1:0]   in_flight;
    logic [LOAD_W-1:0]  load;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_empty;

    // Tag pipe mirrors the FIR latency so the tag reaches the last stage when fir_y is valid.
    assign tag_d[0] = fir_ce & next_tag;
    for (genvar gi = 1; gi < FIR_LAT; gi++) begin : g_tag
        assign tag_d[gi] = tag_q[gi-1];
    end

    assign busy    = (state_q != IDLE);
    assign m_valid = ~fifo_empty;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < FIR_LAT; i++) begin
            in_flight = in_flight + CNT_W'(tag_q[i]);
        end
        load      = {1'b0, fifo_cnt} + {1'b0, in_flight};
        next_tag  = (n_q == N_LAST) && (phase_q == '0);
        // Only kept samples need a reserved FIFO slot; warm-up and skipped samples flow freely.
        credit_ok = ~next_tag | (load < LOAD_MAX);
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        phase_d     = phase_q;
        flush_cnt_d = flush_cnt_q;
        s_ready     = 1'b0;
        fir_ce      = 1'b0;
        fir_x       = '0;
        fir_clr_n   = 1'b1;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = CLR;
            end
            CLR: begin
                fir_clr_n   = 1'b0;
                n_d         = '0;
                phase_d     = '0;
                flush_cnt_d = '0;
                state_d     = FILL;
            end
            FILL, RUN: begin
                fir_x = s_data;
                if (flush_req) begin
                    state_d = FLUSH;
                end else begin
                    s_ready = enable & credit_ok;
                    fir_ce  = s_valid & s_ready;
                end
            end
            FLUSH: begin
                fir_ce = credit_ok;
                if (fir_ce) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FLUSH_END) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((tag_q == '0) && fifo_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fir_ce) begin
            if (n_q != N_LAST) begin
                n_d = n_q + 1'b1;
            end else begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            end
        end

        if ((state_q == FILL) && (state_d == FILL) && (n_d == N_LAST)) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            phase_q     <= '0;
            flush_cnt_q <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            phase_q     <= phase_d;
            flush_cnt_q <= flush_cnt_d;
            tag_q       <= tag_d;
        end
    end

    hdec_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (tag_q[FIR_LAT-1]),
        .din   (fir_y),
        .pop   (m_ready),
        .dout  (m_data),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

endmodule

// File: tb/tb_hdec_5_stream_ctrl.sv
// Bench: controller paired with a behavioural enable-gated transposed FIR and a convolution scoreboard.
module tb_hdec_5_stream_ctrl;

    localparam int NT = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush_req;
    logic        busy;
    logic        done;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [19:0] m_data;
    logic        fir_clr_n;
    logic        fir_ce;
    logic [7:0]  fir_x;
    logic [19:0] fir_y;

    int coef [NT] = '{-1, 1, 7, 9, -4, -28, -36, 7, 105, 210, 256,
                      210, 105, 7, -36, -28, -4, 9, 7, 1, -1};

    int     n_vec = 0;
    int     n_err = 0;
    longint exp_q [$];
    int     hist [512];
    int     n_mon = 0;
    int     out_cnt = 0;
    int     done_cnt = 0;
    int     acc_cnt = 0;

    always #5 clk = ~clk;

    hdec_5_stream_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush_req (flush_req),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .fir_clr_n (fir_clr_n),
        .fir_ce    (fir_ce),
        .fir_x     (fir_x),
        .fir_y     (fir_y)
    );

    // Transposed-form FIR: MAC chain advances on fir_ce, Y register every clock.
    int mac [NT];
    int y_m;
    always @(posedge clk) begin
        if (!fir_clr_n) begin
            for (int k = 0; k < NT; k++) mac[k] <= 0;
            y_m <= 0;
        end else begin
            if (fir_ce) begin
                for (int k = 0; k < NT-1; k++)
                    mac[k] <= coef[k] * int'($signed(fir_x)) + mac[k+1];
                mac[NT-1] <= coef[NT-1] * int'($signed(fir_x));
            end
            y_m <= mac[0];
        end
    end
    assign fir_y = y_m[19:0];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle, model what is accepted and check what is popped.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            n_mon = 0;
        end else begin
            if (!fir_clr_n) n_mon = 0;
            if (fir_ce) begin
                int x;
                x = (s_valid && s_ready) ? int'($signed(s_data)) : 0;
                if (n_mon < 512) hist[n_mon] = x;
                if (n_mon >= NT-1 && ((n_mon - (NT-1)) % 5) == 0) begin
                    longint acc;
                    acc = 0;
                    for (int k = 0; k < NT; k++) acc += longint'(coef[k]) * hist[n_mon-k];
                    exp_q.push_back(acc);
                end
                n_mon++;
            end
            if (m_valid && m_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) check("extra_output", 1, 0);
                else check("m_data", longint'($signed(m_data)), exp_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stall);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        if (stall) while ($urandom_range(1, 0) == 1) begin s_valid = 1'b0; cyc(); end
        s_valid = 1'b1;
        s_data  = d;
        do begin
            @(negedge clk);
            acc = s_ready;
            cyc();
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic start();
        out_cnt  = 0;
        done_cnt = 0;
        enable   = 1'b1;
        cyc();
        cyc();
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 500) begin cyc(); guard++; end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        enable = 1'b0;
        reset  = 1'b0;
        cyc();
        reset  = 1'b1;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; flush_req = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) cyc();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fir_ce", fir_ce, 0);
        check("rst_fir_x", fir_x, 0);
        check("rst_fir_clr_n", fir_clr_n, 1);
        reset = 1'b1;
        cyc();

        // DC, continuous stream
        start();
        for (int i = 0; i < 40; i++) send(8'd10, 1'b0);
        wait_drain();
        check("dc_out_count", out_cnt, 4);
        pulse_reset();

        // Impulse after fill, stalled stream
        start();
        for (int i = 0; i < 45; i++) send((i == 20) ? 8'd1 : 8'd0, 1'b1);
        wait_drain();
        check("imp_out_count", out_cnt, 5);
        pulse_reset();

        // DC, stalled stream
        start();
        for (int i = 0; i < 40; i++) send(8'd10, 1'b1);
        wait_drain();
        check("dcstall_out_count", out_cnt, 4);
        pulse_reset();

        // Backpressure: FIFO fills, next kept sample is refused
        m_ready = 1'b0;
        start();
        s_valid = 1'b1; s_data = 8'd10; acc_cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (s_ready) acc_cnt++;
            cyc();
        end
        @(negedge clk);
        check("bp_s_ready", s_ready, 0);
        check("bp_m_valid", m_valid, 1);
        s_valid = 1'b0;
        cyc();
        check("bp_accepted", acc_cnt, 40);
        check("bp_pending", exp_q.size(), 4);
        m_ready = 1'b1;
        wait_drain();
        check("bp_out_count", out_cnt, 4);
        pulse_reset();

        // Flush after 23 samples
        start();
        for (int i = 0; i < 23; i++) send(8'd10, 1'b0);
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        begin
            int guard;
            guard = 0;
            while (busy && guard < 400) begin cyc(); guard++; end
        end
        check("flush_busy", busy, 0);
        check("flush_done_count", done_cnt, 1);
        check("flush_out_count", out_cnt, 5);
        check("flush_pending", exp_q.size(), 0);
        enable = 1'b0;
        repeat (3) cyc();
        check("flush_done_once", done_cnt, 1);
        pulse_reset();

        // Reset in RUN with two buffered outputs
        m_ready = 1'b0;
        start();
        for (int i = 0; i < 26; i++) send(8'd10, 1'b0);
        repeat (4) cyc();
        check("mid_m_valid_before", m_valid, 1);
        check("mid_pending_before", exp_q.size(), 2);
        reset = 1'b0;
        cyc();
        check("mid_m_valid", m_valid, 0);
        check("mid_s_ready", s_ready, 0);
        check("mid_busy", busy, 0);
        reset = 1'b1;
        enable = 1'b0;
        m_ready = 1'b1;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
